// File: rtl/hyper_cfg_arb.sv
// Round-robin arbiter and sequencer sharing the HyperBus macro configuration port
// among several register-file requesters, with a watchdog that aborts hung accesses.
module hyper_cfg_arb #(
    parameter int NR_REQ  = 2,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic [NR_REQ-1:0]        req_valid_i,
    input  logic [NR_REQ-1:0]        req_rwn_i,
    input  logic [NR_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NR_REQ*DATA_W-1:0] req_data_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]        req_rdata_o,
    output logic                     req_err_o,
    output logic                     mac_valid_o,
    output logic                     mac_rwn_o,
    output logic [ADDR_W-1:0]        mac_addr_o,
    output logic [DATA_W-1:0]        mac_data_o,
    input  logic                     mac_ready_i,
    input  logic [DATA_W-1:0]        mac_rdata_i,
    output logic [7:0]               timeout_cnt_o
);

    localparam int PTR_W = $clog2(NR_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    gnt_q;
    logic [PTR_W-1:0]    gnt;
    logic                found;
    int                  idx;
    logic                rwn_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [WD_W-1:0]     wdog_q;
    logic [7:0]          tcnt_q;
    logic                wd_hit;

    assign wd_hit        = (wdog_q == WD_W'(TIMEOUT - 1));
    assign timeout_cnt_o = tcnt_q;

    // First pending requester at or above ptr, wrapping around
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NR_REQ) idx = idx - NR_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                gnt   = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mac_valid_o = 1'b0;
        mac_rwn_o   = 1'b0;
        mac_addr_o  = '0;
        mac_data_o  = '0;
        req_ready_o = '0;
        req_rdata_o = '0;
        req_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) state_d = BUSY;
            end
            BUSY: begin
                mac_valid_o = 1'b1;
                mac_rwn_o   = rwn_q;
                mac_addr_o  = addr_q;
                mac_data_o  = data_q;
                if (mac_ready_i || wd_hit) state_d = DONE;
            end
            DONE: begin
                req_ready_o[gnt_q] = 1'b1;
                req_rdata_o        = rdata_q;
                req_err_o          = err_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched access, watchdog and completion data; a macro ack beats a watchdog expiry
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            gnt_q   <= '0;
            rwn_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (found) begin
                        gnt_q  <= gnt;
                        rwn_q  <= req_rwn_i[gnt];
                        addr_q <= req_addr_i[int'(gnt)*ADDR_W +: ADDR_W];
                        data_q <= req_data_i[int'(gnt)*DATA_W +: DATA_W];
                        if (int'(gnt) == NR_REQ - 1) ptr_q <= '0;
                        else                         ptr_q <= gnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (mac_ready_i) begin
                        rdata_q <= rwn_q ? mac_rdata_i : '0;
                        err_q   <= 1'b0;
                    end else if (wd_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_cfg_arb.sv
// Directed testbench for hyper_cfg_arb: single write, read, round-robin,
// timeout, ready/timeout collision and reset in the middle of an access.
module tb_hyper_cfg_arb;

    localparam int NR_REQ  = 2;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    logic                     clk;
    logic                     rst;
    logic [NR_REQ-1:0]        req_valid;
    logic [NR_REQ-1:0]        req_rwn;
    logic [NR_REQ*ADDR_W-1:0] req_addr;
    logic [NR_REQ*DATA_W-1:0] req_data;
    logic [NR_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]        req_rdata;
    logic                     req_err;
    logic                     mac_valid;
    logic                     mac_rwn;
    logic [ADDR_W-1:0]        mac_addr;
    logic [DATA_W-1:0]        mac_data;
    logic                     mac_ready;
    logic [DATA_W-1:0]        mac_rdata;
    logic [7:0]               timeout_cnt;

    int total = 0;
    int bad   = 0;

    hyper_cfg_arb #(
        .NR_REQ(NR_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk_i    (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_rwn_i    (req_rwn),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .req_rdata_o  (req_rdata),
        .req_err_o    (req_err),
        .mac_valid_o  (mac_valid),
        .mac_rwn_o    (mac_rwn),
        .mac_addr_o   (mac_addr),
        .mac_data_o   (mac_data),
        .mac_ready_i  (mac_ready),
        .mac_rdata_i  (mac_rdata),
        .timeout_cnt_o(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_rwn = '0; req_addr = '0; req_data = '0;
        mac_ready = 1'b0; mac_rdata = '0;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=00", req_ready); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", req_rdata); end
        total++; if (req_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", req_err); end
        total++; if (mac_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mac_valid got=%b exp=0", mac_valid); end
        total++; if ({mac_rwn, mac_addr, mac_data} !== 39'h0) begin bad++; $display("[TB] FAIL reset_mac_bus got=%h exp=0", {mac_rwn, mac_addr, mac_data}); end
        total++; if (timeout_cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_tcnt got=%h exp=00", timeout_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        req_valid = 2'b01; req_rwn = 2'b00;
        req_addr[0 +: ADDR_W] = 6'h05; req_data[0 +: DATA_W] = 32'hA5A5_0001;
        mac_rdata = 32'h1234_5678;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if ({mac_valid, mac_rwn, mac_addr, mac_data} !== {1'b1, 1'b0, 6'h05, 32'hA5A5_0001}) begin
                bad++; $display("[TB] FAIL wr_mac_stable c=%0d got=%b/%b/%h/%h exp=1/0/05/a5a50001", c, mac_valid, mac_rwn, mac_addr, mac_data); end
            total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL wr_early_ready c=%0d got=%b exp=00", c, req_ready); end
            if (c == 3) mac_ready = 1'b1;
        end
        @(negedge clk);
        mac_ready = 1'b0; req_valid = 2'b00;
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL wr_ready got=%b exp=01", req_ready); end
        total++; if (req_err !== 1'b0) begin bad++; $display("[TB] FAIL wr_err got=%b exp=0", req_err); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("[TB] FAIL wr_rdata got=%h exp=0", req_rdata); end
        total++; if (mac_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_mac_valid_done got=%b exp=0", mac_valid); end
        @(negedge clk);
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL wr_ready_single got=%b exp=00", req_ready); end
    endtask

    task automatic test_read();
        // ptr is now 1; requester 1 reads
        req_valid = 2'b10; req_rwn = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 6'h21; req_data[DATA_W +: DATA_W] = 32'h5555_AAAA;
        @(negedge clk);
        total++; if ({mac_valid, mac_rwn, mac_addr} !== {1'b1, 1'b1, 6'h21}) begin
            bad++; $display("[TB] FAIL rd_mac got=%b/%b/%h exp=1/1/21", mac_valid, mac_rwn, mac_addr); end
        mac_ready = 1'b1; mac_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mac_ready = 1'b0; req_valid = 2'b00;
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL rd_ready got=%b exp=10", req_ready); end
        total++; if (req_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL rd_rdata got=%h exp=deadbeef", req_rdata); end
        total++; if (req_err !== 1'b0) begin bad++; $display("[TB] FAIL rd_err got=%b exp=0", req_err); end
        @(negedge clk);
        total++; if (req_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rd_rdata_idle got=%h exp=0", req_rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        logic [5:0] exp_addr;
        // ptr is 0 again; macro always ready, both requesters always pending
        req_valid = 2'b11; req_rwn = 2'b11;
        req_addr[0 +: ADDR_W] = 6'h11; req_addr[ADDR_W +: ADDR_W] = 6'h22;
        mac_ready = 1'b1; mac_rdata = 32'h0BAD_CAFE;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_rdy  = 2'b00;
            exp_addr = 6'h00;
            if (i % 3 == 2) exp_rdy = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (i % 3 == 1) exp_addr = ((i / 3) % 2 == 0) ? 6'h11 : 6'h22;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL rr_ready i=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
            total++; if (mac_addr !== exp_addr) begin bad++; $display("[TB] FAIL rr_addr i=%0d got=%h exp=%h", i, mac_addr, exp_addr); end
            if (i == 11) begin req_valid = 2'b00; mac_ready = 1'b0; end
        end
    endtask

    task automatic test_timeout();
        int busy;
        bit done;
        busy = 0; done = 0;
        // ptr is 0; a read that the macro never acknowledges
        req_valid = 2'b01; req_rwn = 2'b01;
        req_addr[0 +: ADDR_W] = 6'h3F; mac_ready = 1'b0; mac_rdata = 32'hFFFF_FFFF;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (mac_valid) busy++;
            if (req_ready !== 2'b00) done = 1;
        end
        req_valid = 2'b00;
        total++; if (!done) begin bad++; $display("[TB] FAIL to_no_ready got=none exp=ready within 200 cycles"); end
        total++; if (busy !== 64) begin bad++; $display("[TB] FAIL to_busy_cycles got=%0d exp=64", busy); end
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL to_ready got=%b exp=01", req_ready); end
        total++; if (req_err !== 1'b1) begin bad++; $display("[TB] FAIL to_err got=%b exp=1", req_err); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("[TB] FAIL to_rdata got=%h exp=0", req_rdata); end
        total++; if (timeout_cnt !== 8'd1) begin bad++; $display("[TB] FAIL to_tcnt got=%0d exp=1", timeout_cnt); end
        @(negedge clk);
        total++; if (req_err !== 1'b0) begin bad++; $display("[TB] FAIL to_err_idle got=%b exp=0", req_err); end
    endtask

    task automatic test_collision();
        int busy;
        bit done;
        busy = 0; done = 0;
        // ptr is 1; ack arrives in the very cycle the watchdog expires
        req_valid = 2'b10; req_rwn = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 6'h2A; mac_rdata = 32'hCAFE_F00D;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) done = 1;
            else if (mac_valid) begin
                busy++;
                if (busy == 64) mac_ready = 1'b1;
            end
        end
        mac_ready = 1'b0; req_valid = 2'b00;
        total++; if (!done) begin bad++; $display("[TB] FAIL col_no_ready got=none exp=ready within 200 cycles"); end
        total++; if (busy !== 64) begin bad++; $display("[TB] FAIL col_busy_cycles got=%0d exp=64", busy); end
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL col_ready got=%b exp=10", req_ready); end
        total++; if (req_err !== 1'b0) begin bad++; $display("[TB] FAIL col_err got=%b exp=0", req_err); end
        total++; if (req_rdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL col_rdata got=%h exp=cafef00d", req_rdata); end
        total++; if (timeout_cnt !== 8'd1) begin bad++; $display("[TB] FAIL col_tcnt got=%0d exp=1", timeout_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        // ptr is 0; requester 0 starts an access that gets reset away
        req_valid = 2'b01; req_rwn = 2'b00;
        req_addr[0 +: ADDR_W] = 6'h07; req_data[0 +: DATA_W] = 32'h7777_0007;
        repeat (2) @(negedge clk);
        total++; if (mac_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_busy got=%b exp=1", mac_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        total++; if ({req_ready, req_err, mac_valid, mac_rwn} !== 5'b0) begin
            bad++; $display("[TB] FAIL rm_ctrl got=%b exp=00000", {req_ready, req_err, mac_valid, mac_rwn}); end
        total++; if ({req_rdata, mac_addr, mac_data, timeout_cnt} !== 78'h0) begin
            bad++; $display("[TB] FAIL rm_data got=%h exp=0", {req_rdata, mac_addr, mac_data, timeout_cnt}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rm_no_pulse i=%0d got=%b exp=00", i, req_ready); end
        end
        req_valid = 2'b10; req_rwn = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 6'h33;
        @(negedge clk);
        total++; if ({mac_valid, mac_addr} !== {1'b1, 6'h33}) begin
            bad++; $display("[TB] FAIL rm_regrant got=%b/%h exp=1/33", mac_valid, mac_addr); end
        mac_ready = 1'b1; mac_rdata = 32'h0000_0033;
        @(negedge clk);
        mac_ready = 1'b0; req_valid = 2'b00;
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL rm_ready got=%b exp=10", req_ready); end
        total++; if (req_rdata !== 32'h0000_0033) begin bad++; $display("[TB] FAIL rm_rdata got=%h exp=00000033", req_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
